// File: rtl/async_fifo_if.sv
// FIFO handshake bundle: write side (winc/wdata/full) and read side (rinc/rdata/empty).
// ASYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
interface async_fifo_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  full;
  logic                  empty;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;

  modport master (output winc, wdata, rinc, input rdata, full, empty, overflow, underflow);
  modport slave  (input winc, wdata, rinc, output rdata, full, empty, overflow, underflow);
`else
  modport master (output winc, wdata, rinc, input rdata, full, empty);
  modport slave  (input winc, wdata, rinc, output rdata, full, empty);
`endif
endinterface

// File: rtl/async_fifo.sv
// Gray-pointer FIFO with 2-flop pointer synchronizers, single clock wclk; write-to-readable 3 edges, rdata registered.
// winc ignored while full, rinc ignored while empty; ASYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module async_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic          wclk,
  input  logic          wreset,
  async_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_MASK = {2'b11, {(ADDR_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [ADDR_WIDTH:0] wbin, rbin, wgray, rgray;
  logic [ADDR_WIDTH:0] wbin_nxt, rbin_nxt, wgray_nxt, rgray_nxt;
  logic [ADDR_WIDTH:0] rq1_wgray, rq2_wgray, wq1_rgray, wq2_rgray;
  logic                full, empty, wr_en, rd_en;

  assign empty = (rgray == rq2_wgray);
  // full: write pointer has lapped the synchronized read pointer by exactly one depth
  assign full  = (wgray == (wq2_rgray ^ FULL_MASK));
  assign wr_en = bus.winc & ~full;
  assign rd_en = bus.rinc & ~empty;

  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.rdata = rdata_q;

  always_comb begin
    wbin_nxt  = wbin + {{ADDR_WIDTH{1'b0}}, wr_en};
    rbin_nxt  = rbin + {{ADDR_WIDTH{1'b0}}, rd_en};
    wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1);
    rgray_nxt = rbin_nxt ^ (rbin_nxt >> 1);
  end

  always_ff @(posedge wclk) begin
    if (wreset) begin
      wbin      <= '0;
      rbin      <= '0;
      wgray     <= '0;
      rgray     <= '0;
      rq1_wgray <= '0;
      rq2_wgray <= '0;
      wq1_rgray <= '0;
      wq2_rgray <= '0;
      rdata_q   <= '0;
    end else begin
      wbin      <= wbin_nxt;
      rbin      <= rbin_nxt;
      wgray     <= wgray_nxt;
      rgray     <= rgray_nxt;
      rq1_wgray <= wgray;
      rq2_wgray <= rq1_wgray;
      wq1_rgray <= rgray;
      wq2_rgray <= wq1_rgray;
      if (rd_en) rdata_q <= mem[rbin[ADDR_WIDTH-1:0]];
    end
  end

  // Storage is never cleared; reset only discards it by zeroing the pointers.
  always_ff @(posedge wclk) begin
    if (wr_en && !wreset) mem[wbin[ADDR_WIDTH-1:0]] <= bus.wdata;
  end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge wclk) begin
    if (wreset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.winc && full)  overflow_q  <= 1'b1;
      if (bus.rinc && empty) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: count/queue reference model compared every cycle, plus directed literal checks.
module tb_async_fifo;
  localparam int DW    = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic wclk   = 1'b0;
  logic wreset = 1'b1;

  async_fifo_if #(.DATA_WIDTH(DW)) bus();

  async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .wclk   (wclk),
    .wreset (wreset),
    .bus    (bus)
  );

  always #5 wclk = ~wclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Reference model: word queue plus total write/read counts; each side sees the other's count two edges late.
  bit model_on = 1'b0;
  int mq[$];
  int wcnt, rcnt, wc_d1, wc_d2, rc_d1, rc_d2;
  bit m_empty = 1'b1;
  bit m_full  = 1'b0;
  int m_rdata = 0;
  bit m_ovf   = 1'b0;
  bit m_unf   = 1'b0;

  always @(posedge wclk) begin
    bit aw, ar;
    if (wreset) begin
      mq.delete();
      wcnt = 0; rcnt = 0; wc_d1 = 0; wc_d2 = 0; rc_d1 = 0; rc_d2 = 0;
      m_rdata = 0; m_ovf = 1'b0; m_unf = 1'b0;
      model_on = 1'b1;
    end else begin
      aw = bus.winc && !m_full;
      ar = bus.rinc && !m_empty;
      if (bus.winc && m_full)  m_ovf = 1'b1;
      if (bus.rinc && m_empty) m_unf = 1'b1;
      wc_d2 = wc_d1; wc_d1 = wcnt;
      rc_d2 = rc_d1; rc_d1 = rcnt;
      if (aw) begin mq.push_back(int'(bus.wdata)); wcnt++; end
      if (ar) begin m_rdata = mq.pop_front(); rcnt++; end
    end
    m_empty = (rcnt == wc_d2);
    m_full  = ((wcnt - rc_d2) == DEPTH);
  end

  always @(negedge wclk) begin
    if (model_on) begin
      chk("cyc_empty", bus.empty, m_empty);
      chk("cyc_full",  bus.full,  m_full);
      chk("cyc_rdata", bus.rdata, m_rdata);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
      chk("cyc_overflow",  bus.overflow,  m_ovf);
      chk("cyc_underflow", bus.underflow, m_unf);
`endif
    end
  end

  initial begin
    int wi, got, n;
    bit ww, wr;
    bus.winc = 1'b0; bus.wdata = '0; bus.rinc = 1'b0;
    wreset = 1'b1;
    tick();
    wreset = 1'b0;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full",  bus.full,  0);
    chk("rst_rdata", bus.rdata, 0);

    // single word, continuous read request
    bus.winc = 1'b1; bus.wdata = 4'd1; bus.rinc = 1'b1;
    tick();
    bus.winc = 1'b0;
    chk("sw_empty_e1", bus.empty, 1);
    tick();
    chk("sw_empty_e2", bus.empty, 1);
    tick();
    chk("sw_empty_e3", bus.empty, 0);
    chk("sw_rdata_e3", bus.rdata, 0);
    tick();
    chk("sw_rdata_e4", bus.rdata, 1);
    chk("sw_empty_e4", bus.empty, 1);
    bus.rinc = 1'b0;

    // fill to full, then one ignored write
    for (int i = 0; i < 8; i++) begin
      bus.winc = 1'b1; bus.wdata = 4'(2*i+1);
      tick();
    end
    chk("fill_full", bus.full, 1);
    bus.wdata = 4'd2;
    tick();
    bus.winc = 1'b0;
    chk("fill_full_hold", bus.full, 1);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    chk("fill_overflow", bus.overflow, 1);
`endif
    tick(); tick();
    bus.rinc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_dat", bus.rdata, 2*i+1);
      if (i == 0) chk("drain_full_r1", bus.full, 1);
      if (i == 2) chk("drain_full_r3", bus.full, 0);
    end
    chk("drain_empty", bus.empty, 1);
    bus.rinc = 1'b0;
    tick();

    // wrap-around with concurrent reads
    wi = 0; got = 0;
    bus.rinc = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
      bus.winc  = (wi < 20);
      bus.wdata = 4'(wi % 16);
      ww = bus.winc && !bus.full;
      wr = bus.rinc && !bus.empty;
      tick();
      if (ww) wi++;
      if (wr) begin
        chk("wrap_dat", bus.rdata, got % 16);
        got++;
      end
    end
    bus.winc = 1'b0; bus.rinc = 1'b0;
    chk("wrap_cnt", got, 20);
    tick();

    // simultaneous read/write with 4 words resident
    for (int i = 0; i < 4; i++) begin
      bus.winc = 1'b1; bus.wdata = 4'(10+i);
      tick();
    end
    bus.winc = 1'b0;
    tick(); tick();
    bus.winc = 1'b1; bus.rinc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.wdata = 4'(i);
      tick();
      chk("sim_dat", bus.rdata, (i < 4) ? 10+i : i-4);
    end
    bus.winc = 1'b0; bus.rinc = 1'b0;
    tick(); tick(); tick();
    n = 0;
    bus.rinc = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      wr = !bus.empty;
      tick();
      if (wr) begin
        chk("sim_tail", bus.rdata, 6+n);
        n++;
      end
    end
    bus.rinc = 1'b0;
    chk("sim_occ", n, 4);

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    wreset = 1'b1; tick(); wreset = 1'b0;
    chk("ef_ovf_clr", bus.overflow, 0);
    chk("ef_unf_clr", bus.underflow, 0);
    bus.rinc = 1'b1; tick(); bus.rinc = 1'b0;
    chk("ef_unf_set", bus.underflow, 1);
    tick();
    chk("ef_unf_hold", bus.underflow, 1);
    chk("ef_ovf_quiet", bus.overflow, 0);
    for (int i = 0; i < 9; i++) begin
      bus.winc = 1'b1; bus.wdata = 4'(i);
      tick();
    end
    bus.winc = 1'b0;
    chk("ef_ovf_set", bus.overflow, 1);
    wreset = 1'b1; tick(); wreset = 1'b0;
    chk("ef_ovf_rst", bus.overflow, 0);
    chk("ef_unf_rst", bus.underflow, 0);
`endif

    // randomized traffic with varying bias and occasional mid-stream reset
    for (int ph = 0; ph < 3; ph++) begin
      for (int cyc = 0; cyc < 600; cyc++) begin
        wreset    = ($urandom_range(0, 249) == 0);
        bus.winc  = ($urandom_range(0, 3) < ((ph == 1) ? 1 : 3));
        bus.rinc  = ($urandom_range(0, 3) < ((ph == 0) ? 1 : 2));
        bus.wdata = 4'($urandom);
        tick();
      end
    end
    wreset = 1'b0; bus.winc = 1'b0; bus.rinc = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
